mem_access_ctrl: RTL and testbench

Sequencer between the MEM pipeline stage and a word-only data memory port with variable latency and no byte enables. Accepts one load/store request at a time. Runs read-modify-write for sb/sh. Extends sub-word load data, flags misaligned accesses and memory timeouts. The pipeline stalls on req_ready low.

---
 rtl/mem_access_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a word-only memory port with variable latency.
// Sub-word stores are done as read-modify-write; sub-word loads are lane-selected and extended.

module mac_lane_merge (
  input  logic       sel_i,
  input  logic [7:0] rd_byte_i,
  input  logic [7:0] wr_byte_i,
  output logic [7:0] byte_o
);
  assign byte_o = sel_i ? wr_byte_i : rd_byte_i;
endmodule

module mem_access_ctrl #(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] ld_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  localparam int NUM_LANES = 4;
  localparam int CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_e         state_q, state_d;
  req_t           req_q, req_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic [1:0]     err_q, err_d;
  logic [31:0]    ld_q, ld_d;

  logic [NUM_LANES-1:0][7:0] rd_lanes, wr_lanes, mrg_lanes;
  logic [NUM_LANES-1:0]      lane_sel;

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         misaligned = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = a[0];
      default:              misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'b0, b};
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'b0, h};
      default: load_ext = w;
    endcase
  endfunction

  // Per-lane merge for sb/sh: a lane takes store data when it is covered by the access.
  assign rd_lanes = mem_rdata;
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [1:0] LANE = 2'(g);
    assign lane_sel[g] = ((req_q.op == OP_SB) && (req_q.addr[1:0] == LANE)) ||
                         ((req_q.op == OP_SH) && (req_q.addr[1] == LANE[1]));
    assign wr_lanes[g] = (req_q.op == OP_SH) ? req_q.wdata[(g % 2) * 8 +: 8]
                                             : req_q.wdata[7:0];
    mac_lane_merge u_merge (
      .sel_i     (lane_sel[g]),
      .rd_byte_i (rd_lanes[g]),
      .wr_byte_i (wr_lanes[g]),
      .byte_o    (mrg_lanes[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      mem_wdata_q <= '0;
      err_q       <= ERR_OK;
      ld_q        <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      ld_q        <= ld_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    ld_d        = ld_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d.op    = req_op;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          cnt_d       = '0;
          if (misaligned(req_op, req_addr[1:0])) begin
            state_d = S_DONE;
            err_d   = ERR_MIS;
            ld_d    = '0;
          end else if (req_op == OP_SW) begin
            state_d     = S_WR;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (mem_ready) begin
          if (req_q.op == OP_SB || req_q.op == OP_SH) begin
            state_d     = S_WR;
            cnt_d       = '0;
            mem_wdata_d = mrg_lanes;
          end else begin
            state_d = S_DONE;
            err_d   = ERR_OK;
            ld_d    = load_ext(req_q.op, req_q.addr[1:0], mem_rdata);
          end
        end else if (cnt_q == CW'(WAIT_MAX - 1)) begin
          state_d = S_DONE;
          err_d   = ERR_TO;
          ld_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR: begin
        if (mem_ready) begin
          state_d = S_DONE;
          err_d   = ERR_OK;
          ld_d    = '0;
        end else if (cnt_q == CW'(WAIT_MAX - 1)) begin
          state_d = S_DONE;
          err_d   = ERR_TO;
          ld_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign req_ready = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_RD) || (state_q == S_WR);
  assign mem_we    = (state_q == S_WR);
  assign mem_addr  = {req_q.addr[31:2], 2'b00};
  assign mem_wdata = mem_wdata_q;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign ld_data   = ld_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level model of memory and results.

module tb_mem_access_ctrl;
  localparam int WAIT_MAX = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        done;
  logic [1:0]  err;
  logic [31:0] ld_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int          cfg_wait = 0;
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [2:0]  nxt_op;
  logic [31:0] nxt_addr, nxt_wdata;

  mem_access_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err), .ld_data(ld_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h40) return 32'h8899AABB;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Memory write side: owns mem.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (rst_n && mem_req && mem_ready && mem_we) begin
        mem[mem_addr[11:2]] = mem_wdata;
        wr_cnt++;
      end
    end
  end

  // Each access phase sees cfg_wait low cycles of mem_ready, then one high.
  initial begin
    int  wl;
    bit  fresh;
    mem_ready = 1'b0;
    wl = 0;
    fresh = 1'b1;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        mem_ready = 1'b0;
        fresh = 1'b1;
      end else begin
        if (fresh) begin
          wl = cfg_wait;
          fresh = 1'b0;
        end
        if (wl == 0) begin
          mem_ready = 1'b1;
          fresh = 1'b1;
        end else begin
          mem_ready = 1'b0;
          wl--;
        end
      end
    end
  end

  // One request, start to finish; called at a negedge with the controller idle.
  task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                     input int w, input bit keep);
    logic [31:0] old, nw, e_ld, mask;
    logic [7:0]  b;
    logic [15:0] h;
    logic [1:0]  e_err;
    int          idx, e_lat, e_req, e_wr, n, waits, reqc, wr0;
    bit          mis, st, rmw;
    idx  = int'(addr[11:2]);
    old  = ref_mem[idx];
    nw   = old;
    st   = (op >= 3'd5);
    rmw  = (op >= 3'd6);
    mis  = ((op == 3'd0 || op == 3'd5) && addr[1:0] != 2'b00) ||
           ((op == 3'd3 || op == 3'd4 || op == 3'd7) && addr[0]);
    e_ld = '0;
    if (mis) begin
      e_err = 2'b01; e_lat = 1; e_req = 0; e_wr = 0;
    end else if (w >= WAIT_MAX) begin
      e_err = 2'b10; e_lat = WAIT_MAX + 1; e_req = WAIT_MAX; e_wr = 0;
    end else begin
      e_err = 2'b00;
      e_lat = rmw ? 2 * w + 3 : w + 2;
      e_req = rmw ? 2 * (w + 1) : w + 1;
      e_wr  = st ? 1 : 0;
      b = 8'(old >> (8 * addr[1:0]));
      h = 16'(old >> (16 * addr[1]));
      case (op)
        3'd0: e_ld = old;
        3'd1: e_ld = 32'($signed(b));
        3'd2: e_ld = 32'(b);
        3'd3: e_ld = 32'($signed(h));
        3'd4: e_ld = 32'(h);
        3'd5: nw = wd;
        3'd6: begin
          mask = 32'hFF << (8 * addr[1:0]);
          nw = (old & ~mask) | ((32'(wd[7:0]) << (8 * addr[1:0])) & mask);
        end
        default: begin
          mask = 32'hFFFF << (16 * addr[1]);
          nw = (old & ~mask) | ((32'(wd[15:0]) << (16 * addr[1])) & mask);
        end
      endcase
    end

    cfg_wait  = w;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    waits = 0;
    while (!req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    chk("accept_wait", 32'(waits), 32'd0);
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    if (keep) begin
      req_op = nxt_op; req_addr = nxt_addr; req_wdata = nxt_wdata;
    end else begin
      req_valid = 1'b0;
    end
    n = 0;
    reqc = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_req) reqc++;
    end while (!done && n < 200);
    chk("latency", 32'(n), 32'(e_lat));
    chk("err", 32'(err), 32'(e_err));
    chk("ld_data", ld_data, e_ld);
    chk("mem_req_cycles", 32'(reqc), 32'(e_req));
    chk("writes", 32'(wr_cnt - wr0), 32'(e_wr));
    chk("mem_word", mem[idx], nw);
    ref_mem[idx] = nw;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("ready_after_done", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int  r, w, any_done;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ld", ld_data, 32'd0);
    rst_n = 1'b1;

    txn(3'd1, 32'h101, 32'h0, 0, 1'b0);
    txn(3'd2, 32'h103, 32'h0, 0, 1'b0);
    txn(3'd3, 32'h102, 32'h0, 0, 1'b0);
    txn(3'd4, 32'h102, 32'h0, 0, 1'b0);
    txn(3'd0, 32'h100, 32'h0, 0, 1'b0);
    txn(3'd6, 32'h102, 32'h123456CD, 2, 1'b0);
    chk("sb_merge_word", mem[32'h40], 32'h88CDAABB);
    txn(3'd7, 32'h101, 32'hFFFF, 0, 1'b0);
    txn(3'd0, 32'h102, 32'h0, 0, 1'b0);
    txn(3'd0, 32'h200, 32'h0, 1000, 1'b0);
    txn(3'd0, 32'h200, 32'h0, WAIT_MAX - 1, 1'b0);
    txn(3'd0, 32'h204, 32'h0, WAIT_MAX, 1'b0);
    txn(3'd7, 32'h10A, 32'hBEEF, 1000, 1'b0);

    nxt_op = 3'd0; nxt_addr = 32'h104; nxt_wdata = 32'h0;
    txn(3'd5, 32'h104, 32'hCAFEF00D, 1, 1'b1);
    txn(3'd0, 32'h104, 32'h0, 0, 1'b0);

    // Reset during the write phase of a halfword store.
    cfg_wait  = 3;
    req_op    = 3'd7;
    req_addr  = 32'h108;
    req_wdata = 32'h5555;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 20 && !mem_we; k++) @(negedge clk);
    chk("reached_wr", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_mem_req", 32'(mem_req), 32'd0);
    chk("async_mem_we", 32'(mem_we), 32'd0);
    chk("async_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 chk("rst_no_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    any_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) any_done++;
    end
    chk("post_rst_no_done", 32'(any_done), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_word", mem[32'h42], ref_mem[32'h42]);

    for (int t = 0; t < 150; t++) begin
      a = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      r = int'($urandom_range(0, 15));
      w = (r == 0) ? WAIT_MAX + 4 : r % 4;
      txn(3'($urandom_range(0, 7)), a, $urandom, w, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got %0d exp %0d", 1, 0);
    $fatal(1, "bench time limit");
  end

endmodule
